// File: rtl/vend_payout_ctrl.sv
// vend_payout_ctrl: sequences one vend transaction. It captures the change
// owed, requests product release, pays the change as dimes then nickels
// (one req/ack handshake per coin), and finally clears the credit FSM.
// Every wait for an ack is bounded by a timer. When the timer expires the
// block parks in a terminal FAULT state.
module vend_payout_ctrl #(
  parameter int CW          = 6,
  parameter int PRICE       = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vend_go,
  input  logic [CW-1:0] credit,
  input  logic          release_ack,
  input  logic          eject_ack,
  output logic          release_req,
  output logic          dime_req,
  output logic          nickel_req,
  output logic          credit_clr,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic          short_pay
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] DIME_C  = CW'(10);
  localparam logic [CW-1:0] NICK_C  = CW'(5);
  localparam logic [TW-1:0] TMO_C   = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] ONE_T   = TW'(1);

  typedef enum logic [2:0] {
    IDLE, RELEASE, CALC, PAY_DIME, PAY_NICK, CLEAR, DONE, FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] change;
  logic [TW-1:0] timer;

  // The remainder that cannot be paid in 5-cent coins, and the payable amount.
  logic [CW-1:0] rem;
  logic [CW-1:0] pay_amt;
  logic          timeout;

  // Derive the unpayable remainder, the payable amount and the timeout flag.
  always_comb begin
    rem     = change % NICK_C;
    pay_amt = change - rem;
    // The timer counts the edges already spent waiting. When it reads
    // ACK_TIMEOUT-1 and the ack is still low, this edge is the
    // ACK_TIMEOUT-th edge since the req rose.
    timeout = (timer == TMO_C);
  end

  // The payout sequencer. All outputs are registered and are updated
  // together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      change      <= '0;
      timer       <= '0;
      release_req <= 1'b0;
      dime_req    <= 1'b0;
      nickel_req  <= 1'b0;
      credit_clr  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      short_pay   <= 1'b0;
    end else begin
      credit_clr <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (vend_go && (credit >= PRICE_C)) begin
            change      <= credit - PRICE_C;
            short_pay   <= 1'b0;
            release_req <= 1'b1;
            busy        <= 1'b1;
            timer       <= '0;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          if (release_ack) begin
            release_req <= 1'b0;
            state       <= CALC;
          end else if (timeout) begin
            release_req <= 1'b0;
            fault       <= 1'b1;
            state       <= FAULT;
          end else begin
            timer <= timer + ONE_T;
          end
        end
        CALC: begin
          // After the first pass the change is always a multiple of 5.
          // Revisiting CALC after each dime therefore never re-flags
          // short_pay. The pass also gives the ejector one idle cycle
          // between coins.
          if (rem != '0) short_pay <= 1'b1;
          change <= pay_amt;
          timer  <= '0;
          if (pay_amt >= DIME_C) begin
            dime_req <= 1'b1;
            state    <= PAY_DIME;
          end else if (pay_amt == NICK_C) begin
            nickel_req <= 1'b1;
            state      <= PAY_NICK;
          end else begin
            credit_clr <= 1'b1;
            state      <= CLEAR;
          end
        end
        PAY_DIME: begin
          if (eject_ack) begin
            dime_req <= 1'b0;
            change   <= change - DIME_C;
            state    <= CALC;
          end else if (timeout) begin
            dime_req <= 1'b0;
            fault    <= 1'b1;
            state    <= FAULT;
          end else begin
            timer <= timer + ONE_T;
          end
        end
        PAY_NICK: begin
          if (eject_ack) begin
            nickel_req <= 1'b0;
            change     <= change - NICK_C;
            credit_clr <= 1'b1;
            state      <= CLEAR;
          end else if (timeout) begin
            nickel_req <= 1'b0;
            fault      <= 1'b1;
            state      <= FAULT;
          end else begin
            timer <= timer + ONE_T;
          end
        end
        CLEAR: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAULT: begin
          // This state is terminal. Only reset leaves it.
          release_req <= 1'b0;
          dime_req    <= 1'b0;
          nickel_req  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// tb_vend_payout_ctrl: directed and randomized vend transactions checked
// against a coin-count model (greedy dimes, then one nickel if needed).
module tb_vend_payout_ctrl;

  localparam int CW    = 6;
  localparam int PRICE = 20;
  localparam int TMO   = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          vend_go;
  logic [CW-1:0] credit;
  logic          release_ack;
  logic          eject_ack;
  logic          release_req;
  logic          dime_req;
  logic          nickel_req;
  logic          credit_clr;
  logic          busy;
  logic          done;
  logic          fault;
  logic          short_pay;

  int checks = 0;
  int errors = 0;

  vend_payout_ctrl #(.CW(CW), .PRICE(PRICE), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .vend_go(vend_go), .credit(credit),
    .release_ack(release_ack), .eject_ack(eject_ack),
    .release_req(release_req), .dime_req(dime_req), .nickel_req(nickel_req),
    .credit_clr(credit_clr), .busy(busy), .done(done), .fault(fault),
    .short_pay(short_pay)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] all_outs();
    return {release_req, dime_req, nickel_req, credit_clr, busy, done, fault, short_pay};
  endfunction

  // Runs one accepted vend. The ack delays are given in cycles of req-high.
  // If inject is set, a stray vend_go is pulsed while the block is busy.
  // If reset_at_dime is nonzero, reset is asserted while dime number
  // reset_at_dime+1 is being requested, and the task returns.
  task automatic run_txn(input int c, input int rd, input int ed, input bit inject,
                         input int reset_at_dime);
    int ch = c - PRICE;
    int exp_d = ch / 10;
    int exp_n = ((ch % 10) >= 5) ? 1 : 0;
    int exp_sp = ((ch % 5) != 0) ? 1 : 0;
    int dimes = 0, nicks = 0, clrs = 0, dhi = 0, nhi = 0;
    int rel_cnt = 0, ej_cnt = 0, cyc = 0;
    bit fin = 0, ack_dime = 0;
    vend_go = 1'b1; credit = CW'(c);
    step();
    vend_go = 1'b0;
    check("busy_start", busy, 1);
    while (!fin && cyc < 300) begin
      if (eject_ack) begin
        if (ack_dime) dimes++; else nicks++;
        eject_ack = 1'b0;
      end
      release_ack = 1'b0;
      if (reset_at_dime != 0 && dimes == reset_at_dime && dime_req) begin
        reset = 1'b1;
        #1;
        check("reset_outs", all_outs(), 0);
        step();
        reset = 1'b0;
        $display("txn credit=%0d aborted by reset after %0d dimes", c, dimes);
        return;
      end
      check("req_excl", dime_req & nickel_req, 0);
      if (release_req) begin
        rel_cnt++;
        if (rel_cnt == rd) begin release_ack = 1'b1; rel_cnt = 0; end
      end
      if (dime_req) begin
        dhi++; ej_cnt++;
        if (ej_cnt == ed) begin eject_ack = 1'b1; ack_dime = 1'b1; ej_cnt = 0; end
      end else if (nickel_req) begin
        nhi++; ej_cnt++;
        if (ej_cnt == ed) begin eject_ack = 1'b1; ack_dime = 1'b0; ej_cnt = 0; end
      end
      if (credit_clr) clrs++;
      if (done) fin = 1;
      vend_go = inject && (cyc == 2);
      if (vend_go) credit = CW'($urandom_range(PRICE, 63));
      if (!fin) step();
      cyc++;
    end
    vend_go = 1'b0;
    check("done_seen", fin, 1);
    check("dimes", dimes, exp_d);
    check("nickels", nicks, exp_n);
    check("credit_clr_cnt", clrs, 1);
    check("dime_hold", dhi, exp_d * ed);
    check("nick_hold", nhi, exp_n * ed);
    check("short_pay", short_pay, exp_sp);
    step();
    check("busy_end", busy, 0);
    check("done_end", done, 0);
    $display("txn credit=%0d rd=%0d ed=%0d dimes=%0d nickels=%0d short_pay=%0d",
             c, rd, ed, dimes, nicks, short_pay);
  endtask

  // Drives a vend_go with credit below the price. The block must stay idle.
  task automatic run_reject(input int c);
    vend_go = 1'b1; credit = CW'(c);
    step();
    vend_go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reject_busy", busy, 0);
      check("reject_reqs", {release_req, dime_req, nickel_req, credit_clr, done}, 0);
      step();
    end
    $display("txn credit=%0d rejected busy=%0d", c, busy);
  endtask

  // Withholds eject_ack and measures when fault rises relative to dime_req.
  task automatic run_timeout();
    int i_d = -1, i_f = -1, clrs = 0;
    vend_go = 1'b1; credit = CW'(30);
    step();
    vend_go = 1'b0;
    for (int i = 0; i < 100 && i_f < 0; i++) begin
      release_ack = release_req;
      if (dime_req && i_d < 0) i_d = i;
      if (fault && i_f < 0) i_f = i;
      if (credit_clr) clrs++;
      if (i_f < 0) step();
    end
    release_ack = 1'b0;
    check("fault_seen", (i_f >= 0), 1);
    check("fault_latency", i_f - i_d, TMO);
    for (int i = 0; i < 10; i++) begin
      if (credit_clr) clrs++;
      check("fault_hold", {fault, busy, release_req, dime_req, nickel_req, done}, 6'b110000);
      step();
    end
    check("fault_no_clr", clrs, 0);
    $display("txn credit=30 timeout fault_latency=%0d", i_f - i_d);
    reset = 1'b1;
    #1;
    check("fault_reset", all_outs(), 0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vend_go = 1'b0; credit = '0;
    release_ack = 1'b0; eject_ack = 1'b0;
    step(); step();
    check("reset_state", all_outs(), 0);
    reset = 1'b0;
    step();

    run_txn(20, 2, 1, 0, 0);
    run_txn(45, 1, 1, 0, 0);
    run_txn(35, 1, 5, 0, 0);
    run_reject(15);
    run_txn(40, 2, 2, 1, 0);
    run_timeout();
    run_txn(45, 2, 2, 0, 1);
    run_txn(22, 1, 1, 0, 0);
    run_txn(63, 3, 2, 0, 0);

    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0)
        run_reject($urandom_range(0, PRICE - 1));
      else
        run_txn($urandom_range(PRICE, 63), $urandom_range(1, 4),
                $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
